// File: rtl/rx_snapshot_capture.sv
// rx_snapshot_capture: grabs a burst of parallel rx_core DAC vectors into a
// buffer once armed and triggered, then replays them one 16-bit lane at a
// time over a valid/ready stream terminated by m_last and a done pulse.
module rx_snapshot_capture #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int DEPTH          = 256
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [16*NUMBER_OF_LINE-1:0]  din,
    input  logic                          arm,
    input  logic                          trigger,
    input  logic                          abort,
    input  logic [$clog2(DEPTH):0]        capture_len,
    output logic [15:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int AWP = AW + 1;
    localparam int LW  = (NUMBER_OF_LINE > 1) ? $clog2(NUMBER_OF_LINE) : 1;
    localparam int VW  = 16 * NUMBER_OF_LINE;

    localparam logic [AW:0]   DEPTH_L   = AWP'(DEPTH);
    localparam logic [AW:0]   ONE_L     = AWP'(1);
    localparam logic [LW-1:0] LAST_LANE = LW'(NUMBER_OF_LINE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW:0]    len_q, len_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]    ld_cnt_q, ld_cnt_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic           pf_valid_q, pf_valid_d;
    logic           out_valid_q, out_valid_d;
    logic [VW-1:0]  out_vec_q, out_vec_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [VW-1:0]  mem [DEPTH];
    logic [VW-1:0]  rd_data_q;

    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  wr_addr;
    logic           handshake;
    logic           lane_end;
    logic           consume;

    assign m_valid = out_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign m_last  = out_valid_q && (lane_q == LAST_LANE) && (ld_cnt_q == len_q);

    // Select the current lane of the output vector register onto m_data.
    always_comb begin
        m_data = '0;
        for (int i = 0; i < NUMBER_OF_LINE; i++) begin
            if (lane_q == LW'(i)) begin
                m_data = out_vec_q[16*i +: 16];
            end
        end
    end

    // Next-state logic: capture sequencing, read prefetch and lane serialisation.
    // The memory output register acts as a one-vector prefetch slot so the next
    // vector is ready by the time the last lane of the current one is accepted.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ld_cnt_d    = ld_cnt_q;
        lane_d      = lane_q;
        pf_valid_d  = pf_valid_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_q[AW-1:0];
        rd_en       = 1'b0;
        consume     = 1'b0;
        handshake   = out_valid_q && m_ready;
        lane_end    = handshake && (lane_q == LAST_LANE);

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    len_d   = ((capture_len == '0) || (capture_len > DEPTH_L)) ? DEPTH_L : capture_len;
                end
            end
            ARMED: begin
                if (trigger) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = ONE_L;
                    state_d  = (len_q == ONE_L) ? READOUT : CAPTURE;
                end
            end
            CAPTURE: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + ONE_L;
                if ((wr_ptr_q + ONE_L) == len_q) begin
                    state_d = READOUT;
                end
            end
            READOUT: begin
                consume = pf_valid_q && (!out_valid_q || lane_end);
                rd_en   = (rd_ptr_q < len_q) && (!pf_valid_q || consume);
                if (rd_en) begin
                    rd_ptr_d   = rd_ptr_q + ONE_L;
                    pf_valid_d = 1'b1;
                end else if (consume) begin
                    pf_valid_d = 1'b0;
                end
                if (consume) begin
                    out_vec_d   = rd_data_q;
                    out_valid_d = 1'b1;
                    lane_d      = '0;
                    ld_cnt_d    = ld_cnt_q + ONE_L;
                end else if (lane_end) begin
                    out_valid_d = 1'b0;
                end else if (handshake) begin
                    lane_d = lane_q + LW'(1);
                end
                if (handshake && m_last) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            wr_en   = 1'b0;
            rd_en   = 1'b0;
        end

        if (state_d != READOUT) begin
            rd_ptr_d    = '0;
            ld_cnt_d    = '0;
            lane_d      = '0;
            pf_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
        if (state_d == IDLE) begin
            wr_ptr_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // Capture buffer: one write port for din vectors, one registered read port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ld_cnt_q    <= '0;
            lane_q      <= '0;
            pf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ld_cnt_q    <= ld_cnt_d;
            lane_q      <= lane_d;
            pf_valid_q  <= pf_valid_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_rx_snapshot_capture.sv
// tb_rx_snapshot_capture: directed bench for rx_snapshot_capture. Vector k
// carries lane i = k*16+i, so every serialised sample has a known value.
module tb_rx_snapshot_capture;

    localparam int NL    = 8;
    localparam int DEPTH = 256;
    localparam int LENW  = $clog2(DEPTH) + 1;

    logic              clock;
    logic              resetn;
    logic [16*NL-1:0]  din;
    logic              arm;
    logic              trigger;
    logic              abort;
    logic [LENW-1:0]   capture_len;
    logic [15:0]       m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;

    int vectorsApplied = 0;
    int miscompares    = 0;

    rx_snapshot_capture #(
        .NUMBER_OF_LINE (NL),
        .DEPTH          (DEPTH)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .din         (din),
        .arm         (arm),
        .trigger     (trigger),
        .abort       (abort),
        .capture_len (capture_len),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    // 100 MHz style free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; outputs are observed and inputs changed 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic driveVector(input int k);
        for (int i = 0; i < NL; i++) begin
            din[16*i +: 16] = 16'(k * 16 + i);
        end
    endtask

    // Arm, trigger after trigDelay cycles, capture len vectors, then drain the stream.
    // stopAfter > 0 returns right after that many transfers are presented.
    task automatic runSnapshot(input int len, input int trigDelay, input bit randomReady,
                               input bit noiseArm, input int stopAfter);
        int effLen;
        int total;
        int limit;
        int got;
        int cyc;
        int lat;
        int bubbles;
        bit stalled;
        bit seenValid;
        logic [15:0] heldData;
        logic [15:0] expData;

        effLen   = (len == 0 || len > DEPTH) ? DEPTH : len;
        total    = effLen * NL;
        limit    = (stopAfter > 0) ? stopAfter : total;
        heldData = '0;

        capture_len = LENW'(len);
        arm = 1'b1;
        applyStimulus();
        arm = noiseArm;
        if (noiseArm) capture_len = LENW'(1);
        checkOutput("busy after arm", {15'b0, busy}, 16'd1);
        for (int i = 1; i < trigDelay; i++) applyStimulus();

        for (int k = 0; k < effLen; k++) begin
            trigger = (k == 0);
            driveVector(k);
            applyStimulus();
        end
        trigger = 1'b0;
        din = {NL{16'hDEAD}};

        got = 0; cyc = 0; lat = -1; bubbles = 0; stalled = 1'b0;
        while (got < limit && cyc < 5000) begin
            m_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && lat < 0) lat = cyc;
            if (lat >= 0 && !m_valid) bubbles++;
            if (m_valid && stalled) checkOutput("stall hold", m_data, heldData);
            if (m_valid && m_ready) begin
                expData = 16'((got / NL) * 16 + (got % NL));
                checkOutput("data", m_data, expData);
                checkOutput("last", {15'b0, m_last}, 16'(got == total - 1));
                got++;
                stalled = 1'b0;
                if (got == total) arm = 1'b0;
            end else begin
                stalled  = m_valid;
                heldData = m_data;
            end
            if (got < limit) begin
                applyStimulus();
                cyc++;
            end
        end
        checkOutput("transfer count", 16'(got), 16'(limit));
        checkOutput("first valid latency", 16'(lat >= 0 && lat <= 2), 16'd1);
        if (!randomReady) checkOutput("bubbles", 16'(bubbles), 16'd0);

        if (stopAfter == 0) begin
            applyStimulus();
            checkOutput("valid after last", {15'b0, m_valid}, 16'd0);
            checkOutput("done pulse", {15'b0, done}, 16'd1);
            checkOutput("busy after last", {15'b0, busy}, 16'd0);
            applyStimulus();
            checkOutput("done width", {15'b0, done}, 16'd0);
            if (noiseArm) begin
                seenValid = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    if (m_valid || busy) seenValid = 1'b1;
                    applyStimulus();
                end
                checkOutput("no second snapshot", {15'b0, seenValid}, 16'd0);
            end
        end
    endtask

    // Directed sequence covering reset, normal capture, stalls, abort and re-arm.
    initial begin
        bit seenValid;

        resetn = 1'b0; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
        capture_len = '0; m_ready = 1'b1; din = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset m_valid", {15'b0, m_valid}, 16'd0);
        checkOutput("reset m_last", {15'b0, m_last}, 16'd0);
        checkOutput("reset busy", {15'b0, busy}, 16'd0);
        checkOutput("reset done", {15'b0, done}, 16'd0);
        checkOutput("reset m_data", m_data, 16'h0000);
        resetn = 1'b1;
        applyStimulus();

        $display("[TB] arm together with abort in IDLE");
        capture_len = LENW'(4); arm = 1'b1; abort = 1'b1;
        applyStimulus();
        arm = 1'b0; abort = 1'b0;
        checkOutput("arm+abort busy", {15'b0, busy}, 16'd0);
        trigger = 1'b1;
        applyStimulus();
        trigger = 1'b0;
        checkOutput("arm+abort stays idle", {15'b0, busy}, 16'd0);

        $display("[TB] basic snapshot, length 4");
        runSnapshot(4, 3, 1'b0, 1'b0, 0);

        $display("[TB] armed without trigger, then abort");
        capture_len = LENW'(4); arm = 1'b1;
        applyStimulus();
        arm = 1'b0;
        seenValid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_valid || done) seenValid = 1'b1;
            applyStimulus();
        end
        checkOutput("armed busy", {15'b0, busy}, 16'd1);
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkOutput("abort busy", {15'b0, busy}, 16'd0);
        checkOutput("abort done", {15'b0, done}, 16'd0);
        checkOutput("armed no output", {15'b0, seenValid}, 16'd0);
        runSnapshot(3, 1, 1'b0, 1'b0, 0);

        $display("[TB] random backpressure, length 2");
        runSnapshot(2, 2, 1'b1, 1'b0, 0);

        $display("[TB] reset during readout");
        runSnapshot(4, 3, 1'b0, 1'b0, 5);
        applyStimulus();
        resetn = 1'b0;
        applyStimulus();
        resetn = 1'b1;
        checkOutput("mid reset m_valid", {15'b0, m_valid}, 16'd0);
        checkOutput("mid reset m_last", {15'b0, m_last}, 16'd0);
        checkOutput("mid reset busy", {15'b0, busy}, 16'd0);
        checkOutput("mid reset done", {15'b0, done}, 16'd0);
        checkOutput("mid reset m_data", m_data, 16'h0000);
        runSnapshot(1, 2, 1'b0, 1'b0, 0);

        $display("[TB] abort during readout");
        runSnapshot(2, 1, 1'b0, 1'b0, 3);
        applyStimulus();
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkOutput("rd abort m_valid", {15'b0, m_valid}, 16'd0);
        checkOutput("rd abort done", {15'b0, done}, 16'd0);
        checkOutput("rd abort busy", {15'b0, busy}, 16'd0);

        $display("[TB] arm held through capture and readout");
        runSnapshot(4, 2, 1'b0, 1'b1, 0);

        $display("[TB] full depth snapshot, capture_len 0");
        runSnapshot(0, 2, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
